// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage between the PC and the decoder.
// Samples pc_addr when a fetch starts and runs a req/ack read on instruction
// memory. The returned byte is captured into the IR and offered to the
// decoder with a valid/ready handshake. fetch_done pulses as the PC-advance
// strobe. Handles branch flush, and a memory timeout that loads NOP_OPCODE.
//
// Ports:
//   CLK, areset      clock, synchronous active-high reset
//   fetch_en         permit starting a new fetch
//   flush            branch taken; drop the in-flight fetch and the IR
//   pc_addr[7:0]     PC value, sampled when a fetch starts
//   mem_req          memory read request (level)
//   mem_addr[7:0]    memory read address, stable while mem_req=1
//   mem_ack          read complete; mem_rdata valid this cycle
//   mem_rdata[7:0]   instruction byte returned by memory
//   ir[7:0]          instruction register
//   ir_pc[7:0]       address the IR was fetched from
//   ir_valid         IR holds an undelivered instruction
//   ir_ready         decoder accepts the IR this cycle
//   fetch_done       1-cycle pulse when the IR is loaded from memory
//   busy             state != IDLE
//   fault            sticky timeout flag, cleared only by areset
module instr_fetch #(
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [7:0]  NOP_OPCODE = 8'h00
) (
  input  logic       CLK,
  input  logic       areset,
  input  logic       fetch_en,
  input  logic       flush,
  input  logic [7:0] pc_addr,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [7:0] ir,
  output logic [7:0] ir_pc,
  output logic       ir_valid,
  input  logic       ir_ready,
  output logic       fetch_done,
  output logic       busy,
  output logic       fault
);

  // A zero TIMEOUT disables the timeout; keep the counter at least 1 bit wide.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]       state, state_n;
  logic             mem_req_n, ir_valid_n, fetch_done_n, fault_n;
  logic [7:0]       mem_addr_n, ir_n, ir_pc_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic             timeout_hit;
  logic             cnt_max;

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign cnt_max     = (wait_cnt == {CNT_W{1'b1}});
  assign busy        = (state != IDLE);

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (areset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= 8'h00;
      ir         <= 8'h00;
      ir_pc      <= 8'h00;
      ir_valid   <= 1'b0;
      fetch_done <= 1'b0;
      fault      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_n;
      mem_req    <= mem_req_n;
      mem_addr   <= mem_addr_n;
      ir         <= ir_n;
      ir_pc      <= ir_pc_n;
      ir_valid   <= ir_valid_n;
      fetch_done <= fetch_done_n;
      fault      <= fault_n;
      wait_cnt   <= wait_cnt_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    mem_req_n    = mem_req;
    mem_addr_n   = mem_addr;
    ir_n         = ir;
    ir_pc_n      = ir_pc;
    ir_valid_n   = ir_valid;
    fetch_done_n = 1'b0;
    fault_n      = fault;
    wait_cnt_n   = wait_cnt;

    case (state)
      IDLE: begin
        if (fetch_en && !flush) begin
          mem_addr_n = pc_addr;
          mem_req_n  = 1'b1;
          wait_cnt_n = '0;
          state_n    = REQ;
        end
      end

      REQ: begin
        if (mem_ack && !flush) begin
          mem_req_n    = 1'b0;
          ir_n         = mem_rdata;
          ir_pc_n      = mem_addr;
          ir_valid_n   = 1'b1;
          fetch_done_n = 1'b1;
          state_n      = HOLD;
        end else if (mem_ack) begin
          mem_req_n = 1'b0;
          state_n   = IDLE;
        end else if (flush) begin
          // The issued request must still complete; wait it out in DISCARD.
          state_n = DISCARD;
        end else if (timeout_hit) begin
          mem_req_n  = 1'b0;
          ir_n       = NOP_OPCODE;
          ir_pc_n    = mem_addr;
          ir_valid_n = 1'b1;
          fault_n    = 1'b1;
          state_n    = HOLD;
        end else if (!cnt_max) begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end

      HOLD: begin
        if (flush) begin
          ir_valid_n = 1'b0;
          state_n    = IDLE;
        end else if (ir_ready && fetch_en) begin
          // Back-to-back fetch without an IDLE bubble.
          ir_valid_n = 1'b0;
          mem_addr_n = pc_addr;
          mem_req_n  = 1'b1;
          wait_cnt_n = '0;
          state_n    = REQ;
        end else if (ir_ready) begin
          ir_valid_n = 1'b0;
          state_n    = IDLE;
        end
      end

      DISCARD: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          state_n   = IDLE;
        end else if (timeout_hit) begin
          mem_req_n = 1'b0;
          fault_n   = 1'b1;
          state_n   = IDLE;
        end else if (!cnt_max) begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch (TIMEOUT=4).
module tb_instr_fetch;

  localparam logic [7:0] NOP = 8'h13;

  logic       CLK;
  logic       areset;
  logic       fetch_en;
  logic       flush;
  logic [7:0] pc_addr;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] ir;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic       ir_ready;
  logic       fetch_done;
  logic       busy;
  logic       fault;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int base;

  instr_fetch #(.TIMEOUT(4), .NOP_OPCODE(NOP)) dut (
    .CLK(CLK), .areset(areset), .fetch_en(fetch_en), .flush(flush),
    .pc_addr(pc_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .fetch_done(fetch_done),
    .busy(busy), .fault(fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count fetch_done pulses, sampled mid-cycle.
  always @(negedge CLK) if (fetch_done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1; fetch_en = 1'b1; flush = 1'b0; pc_addr = 8'h55;
    mem_ack = 1'b1; mem_rdata = 8'hEE; ir_ready = 1'b0;
    tick(); tick();
    total++; if ({mem_req, mem_addr, ir, ir_pc} !== 25'd0) begin bad++; $display("FAIL reset_data got=%b_%h_%h_%h exp=0_00_00_00", mem_req, mem_addr, ir, ir_pc); end
    total++; if ({ir_valid, fetch_done, busy, fault} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {ir_valid, fetch_done, busy, fault}); end
    areset = 1'b0; fetch_en = 1'b0; mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_basic_fetch();
    base = done_cnt;
    pc_addr = 8'h10; fetch_en = 1'b1;
    tick();
    total++; if ({mem_req, mem_addr, busy, ir_valid} !== {1'b1, 8'h10, 1'b1, 1'b0}) begin bad++; $display("FAIL basic_req got=%b_%h_%b_%b exp=1_10_1_0", mem_req, mem_addr, busy, ir_valid); end
    fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0;
    total++; if ({ir, ir_pc} !== 16'hA510) begin bad++; $display("FAIL basic_ir got=%h_%h exp=a5_10", ir, ir_pc); end
    total++; if ({ir_valid, fetch_done, mem_req} !== 3'b110) begin bad++; $display("FAIL basic_flags got=%b exp=110", {ir_valid, fetch_done, mem_req}); end
    tick();
    total++; if (fetch_done !== 1'b0 || done_cnt - base !== 1) begin bad++; $display("FAIL basic_done_pulse got=%b/%0d exp=0/1", fetch_done, done_cnt - base); end
  endtask

  task automatic test_backpressure();
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({ir, ir_valid, mem_req} !== {8'hA5, 1'b1, 1'b0}) begin bad++; $display("FAIL bp_hold%0d got=%h_%b_%b exp=a5_1_0", i, ir, ir_valid, mem_req); end
    end
    ir_ready = 1'b1; fetch_en = 1'b1; pc_addr = 8'h11;
    tick();
    total++; if ({mem_req, mem_addr, ir_valid} !== {1'b1, 8'h11, 1'b0}) begin bad++; $display("FAIL bp_b2b_req got=%b_%h_%b exp=1_11_0", mem_req, mem_addr, ir_valid); end
    ir_ready = 1'b0; fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    total++; if ({ir, ir_pc, ir_valid} !== {8'h5A, 8'h11, 1'b1}) begin bad++; $display("FAIL bp_second_ir got=%h_%h_%b exp=5a_11_1", ir, ir_pc, ir_valid); end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    total++; if ({ir_valid, busy, mem_req} !== 3'b000) begin bad++; $display("FAIL bp_to_idle got=%b exp=000", {ir_valid, busy, mem_req}); end
  endtask

  task automatic test_flush_req();
    base = done_cnt;
    pc_addr = 8'h20; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if ({mem_req, mem_addr, busy} !== {1'b1, 8'h20, 1'b1}) begin bad++; $display("FAIL flush_discard got=%b_%h_%b exp=1_20_1", mem_req, mem_addr, busy); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if ({mem_req, ir_valid} !== 2'b10) begin bad++; $display("FAIL flush_wait%0d got=%b exp=10", i, {mem_req, ir_valid}); end
    end
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    total++; if ({mem_req, busy, ir_valid, ir} !== {3'b000, 8'h5A}) begin bad++; $display("FAIL flush_after_ack got=%b_%b_%b_%h exp=0_0_0_5a", mem_req, busy, ir_valid, ir); end
    tick();
    total++; if (done_cnt - base !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", done_cnt - base); end
  endtask

  task automatic test_flush_collide();
    base = done_cnt;
    pc_addr = 8'h30; fetch_en = 1'b1;
    tick();
    mem_ack = 1'b1; flush = 1'b1; mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    total++; if ({mem_req, ir_valid, busy, ir} !== {3'b000, 8'h5A}) begin bad++; $display("FAIL collide_ack got=%b_%b_%b_%h exp=0_0_0_5a", mem_req, ir_valid, busy, ir); end
    pc_addr = 8'h31;
    tick();
    fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick();
    mem_ack = 1'b0;
    total++; if ({ir, ir_pc, ir_valid} !== {8'hC3, 8'h31, 1'b1}) begin bad++; $display("FAIL collide_load got=%h_%h_%b exp=c3_31_1", ir, ir_pc, ir_valid); end
    flush = 1'b1; ir_ready = 1'b1; fetch_en = 1'b1; pc_addr = 8'h32;
    tick();
    flush = 1'b0; ir_ready = 1'b0; fetch_en = 1'b0;
    total++; if ({ir_valid, mem_req, busy, ir} !== {3'b000, 8'hC3}) begin bad++; $display("FAIL collide_hold_flush got=%b_%b_%b_%h exp=0_0_0_c3", ir_valid, mem_req, busy, ir); end
    tick();
    total++; if (done_cnt - base !== 1) begin bad++; $display("FAIL collide_done_cnt got=%0d exp=1", done_cnt - base); end
  endtask

  task automatic test_back_to_back();
    base = done_cnt;
    pc_addr = 8'h70; mem_rdata = 8'h3C; mem_ack = 1'b1; ir_ready = 1'b1; fetch_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    total++; if ({ir, ir_pc, ir_valid, fetch_done} !== {8'h3C, 8'h70, 2'b11}) begin bad++; $display("FAIL b2b_last got=%h_%h_%b_%b exp=3c_70_1_1", ir, ir_pc, ir_valid, fetch_done); end
    fetch_en = 1'b0; mem_ack = 1'b0;
    tick();
    ir_ready = 1'b0;
    total++; if (done_cnt - base !== 3) begin bad++; $display("FAIL b2b_rate got=%0d exp=3", done_cnt - base); end
  endtask

  task automatic test_timeout();
    base = done_cnt;
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL to_fault_pre got=%b exp=0", fault); end
    pc_addr = 8'h40; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({mem_req, ir_valid, fault} !== 3'b100) begin bad++; $display("FAIL to_wait%0d got=%b exp=100", i, {mem_req, ir_valid, fault}); end
    end
    tick();
    total++; if ({mem_req, ir, ir_pc, ir_valid, fault, fetch_done} !== {1'b0, NOP, 8'h40, 3'b110}) begin bad++; $display("FAIL to_expire got=%b_%h_%h_%b%b%b exp=0_13_40_110", mem_req, ir, ir_pc, ir_valid, fault, fetch_done); end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    // Timeout while discarding: back to IDLE, IR not reloaded.
    pc_addr = 8'h50; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL to_discard_wait got=%b exp=1", mem_req); end
    tick();
    total++; if ({mem_req, busy, ir_valid, fault, ir} !== {4'b0001, NOP}) begin bad++; $display("FAIL to_discard_expire got=%b_%h exp=0001_13", {mem_req, busy, ir_valid, fault}, ir); end
    tick();
    total++; if (fault !== 1'b1 || done_cnt - base !== 0) begin bad++; $display("FAIL to_sticky got=%b/%0d exp=1/0", fault, done_cnt - base); end
  endtask

  task automatic test_reset_mid_req();
    pc_addr = 8'h60; fetch_en = 1'b1;
    tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_mid_req got=%b exp=1", mem_req); end
    areset = 1'b1;
    tick();
    areset = 1'b0; fetch_en = 1'b0;
    total++; if ({mem_req, mem_addr, ir, ir_pc, ir_valid, fetch_done, busy, fault} !== 29'd0) begin bad++; $display("FAIL rst_mid_vals got=%b_%h_%h_%h_%b%b%b%b exp=0", mem_req, mem_addr, ir, ir_pc, ir_valid, fetch_done, busy, fault); end
    mem_ack = 1'b1; mem_rdata = 8'hFF;
    tick();
    mem_ack = 1'b0;
    total++; if ({mem_req, ir_valid, busy, fetch_done, ir} !== {4'b0000, 8'h00}) begin bad++; $display("FAIL rst_late_ack got=%b_%h exp=0000_00", {mem_req, ir_valid, busy, fetch_done}, ir); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_flush_req();
    test_flush_collide();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly downstream of the program counter. It samples the 8-bit PC address, runs a req/ack read on instruction memory, and captures the returned byte into the instruction register (IR). It presents the IR to the decoder with a valid/ready handshake and pulses fetch_done as the PC-advance strobe. It also handles branch flush and memory timeout.

Parameters:
TIMEOUT, 16, max cycles in REQ/DISCARD waiting for mem_ack; 0 disables timeout
NOP_OPCODE, 8'h00, byte loaded into IR on timeout

Ports:
CLK  input  1  clock; all state updates on posedge
areset  input  1  reset, synchronous, active-high
fetch_en  input  1  permit starting a new fetch
flush  input  1  branch taken; discard in-flight fetch and IR
pc_addr  input  8  current PC value, sampled at fetch start
mem_req  output  1  memory read request, level
mem_addr  output  8  memory read address, stable while mem_req=1
mem_ack  input  1  read complete; mem_rdata valid this cycle
mem_rdata  input  8  instruction byte
ir  output  8  instruction register
ir_pc  output  8  address the IR was fetched from
ir_valid  output  1  IR holds an undelivered instruction
ir_ready  input  1  decoder accepts IR this cycle
fetch_done  output  1  1-cycle pulse when IR loaded from memory (PC advance strobe)
busy  output  1  state != IDLE
fault  output  1  sticky; set on any timeout

Behaviour:
- Reset (areset=1 at posedge, overrides all inputs): state=IDLE, mem_req=0, mem_addr=0, ir=0, ir_pc=0, ir_valid=0, fetch_done=0, fault=0, wait_cnt=0.
- fetch_done defaults to 0 every cycle unless set below.
- IDLE:
  - fetch_en=1 and flush=0: mem_addr<=pc_addr, mem_req<=1, wait_cnt<=0, go REQ.
  - flush=1 in IDLE: no effect beyond blocking the start.
- REQ (mem_req=1, mem_addr held):
  - mem_ack=1 and flush=0: mem_req<=0, ir<=mem_rdata, ir_pc<=mem_addr, ir_valid<=1, fetch_done<=1, go HOLD.
  - mem_ack=1 and flush=1: data dropped, mem_req<=0, no fetch_done, go IDLE.
  - mem_ack=0 and flush=1: go DISCARD with mem_req still 1. An issued request is always completed.
  - mem_ack=0, TIMEOUT>0, wait_cnt==TIMEOUT-1: mem_req<=0, ir<=NOP_OPCODE, ir_pc<=mem_addr, ir_valid<=1, fault<=1, no fetch_done, go HOLD.
  - Otherwise wait_cnt<=wait_cnt+1. wait_cnt width is clog2(TIMEOUT+1), and it never wraps.
- HOLD (ir_valid=1, ir/ir_pc stable):
  - flush=1: ir_valid<=0, go IDLE. flush has priority over ir_ready.
  - ir_ready=1 and fetch_en=1: ir_valid<=0, mem_addr<=pc_addr, mem_req<=1, wait_cnt<=0, go REQ. This gives back-to-back fetch with no IDLE bubble.
  - ir_ready=1 and fetch_en=0: ir_valid<=0, go IDLE.
  - Otherwise hold.
- DISCARD (mem_req=1, result will be dropped):
  - mem_ack=1: mem_req<=0, go IDLE. IR and ir_valid are untouched (already 0).
  - Timeout rule as in REQ but to IDLE: mem_req<=0, fault<=1, IR not loaded.
  - flush ignored here.
- Memory contract: mem_ack is only meaningful while mem_req=1; ack with mem_req=0 is ignored. Dropping mem_req on timeout abandons the transaction.
- Throughput: with 1-cycle ack and ir_ready held high, one instruction per 2 cycles (REQ, HOLD).
- Minimum latency: fetch start to ir_valid is 2 posedges when ack arrives in the first REQ cycle.
- Reset mid-transaction: returns to IDLE immediately with mem_req=0. The memory must treat this as abandonment.

Test Plan:
- Reset then basic fetch: areset 2 cycles, pc_addr=8'h10, fetch_en=1, mem ack after 1 cycle with 8'hA5 -> mem_addr=8'h10, ir=8'hA5, ir_pc=8'h10, ir_valid=1, exactly one fetch_done pulse.
- Backpressure: ir_ready=0 for 5 cycles in HOLD -> ir/ir_valid stable, mem_req=0. Then ir_ready=1, fetch_en=1, pc_addr=8'h11 -> mem_req=1 with mem_addr=8'h11 the next cycle.
- Flush in REQ: req at 8'h20, flush pulse before ack, ack 3 cycles later with 8'h77 -> mem_req held until ack, ir_valid never 1, ir unchanged, no fetch_done, busy falls after ack.
- Flush colliding with ack, and flush with ir_ready in HOLD -> data dropped; ir_valid=0 next cycle; no new request issued that cycle.
- Timeout with TIMEOUT=4: mem_ack never asserted -> after 4 REQ cycles mem_req=0, ir=NOP_OPCODE, ir_valid=1, fault=1 (stays 1 until areset), no fetch_done.
- Reset mid-REQ: areset asserted while mem_req=1 -> next cycle all outputs at reset values. A late mem_ack arriving afterwards is ignored.
